spi_reg_ctrl: RTL and testbench

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

---
 rtl/spi_reg_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrl.sv
// SPI register-expander controller: decodes command/data bytes from an SPI
// slave into a four-entry register file and drives the expander pins.
module spi_reg_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  output logic [7:0] tx_data,
  output logic       tx_latch,
  output logic [7:0] pin_out,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_WDATA = 3'd2,
    S_RDATA = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [1:0] A_OUT     = 2'd0;
  localparam logic [1:0] A_DIR     = 2'd1;
  localparam logic [1:0] A_SCRATCH = 2'd2;
  localparam logic [1:0] A_STATUS  = 2'd3;

  state_t      state;
  state_t      state_nxt;

  logic        rx_rdy_q;
  logic        strobe;
  logic        byte_ok;
  logic        cmd_bad;
  logic        cmd_rd;

  logic [7:0]  out_reg;
  logic [7:0]  dir_reg;
  logic [7:0]  scratch_reg;
  logic        err_sticky;
  logic [3:0]  frame_cnt;
  logic [1:0]  addr;
  logic        frame_seen;
  logic        load_req;

  logic        frame_active;
  logic        wr_en;
  logic        err_set;
  logic        addr_load;
  logic        addr_inc;
  logic        load_set;
  logic        frame_end;
  logic [7:0]  status;
  logic [7:0]  rd_mux;

  // A strobe is only a byte while the frame is selected; ss always wins.
  assign strobe  = rx_rdy & ~rx_rdy_q;
  assign byte_ok = strobe & ~ss;
  assign cmd_bad = |rx_data[6:2];
  assign cmd_rd  = rx_data[7];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!ss) state_nxt = S_CMD;
      end
      S_CMD: begin
        if (ss) begin
          state_nxt = S_IDLE;
        end else if (byte_ok) begin
          if (cmd_bad)     state_nxt = S_ERR;
          else if (cmd_rd) state_nxt = S_RDATA;
          else             state_nxt = S_WDATA;
        end
      end
      S_WDATA, S_RDATA, S_ERR: begin
        if (ss) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    frame_active = (state != S_IDLE);
    busy         = frame_active;
    wr_en        = (state == S_WDATA) && byte_ok;
    err_set      = (state == S_CMD) && byte_ok && cmd_bad;
    addr_load    = (state == S_CMD) && byte_ok && !cmd_bad;
    addr_inc     = ((state == S_WDATA) || (state == S_RDATA)) && byte_ok;
    load_set     = ((state == S_CMD) && byte_ok && !cmd_bad && cmd_rd) ||
                   ((state == S_RDATA) && byte_ok);
    frame_end    = (state != S_IDLE) && ss;
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_rdy_q <= 1'b0;
    end else begin
      rx_rdy_q <= rx_rdy;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= 2'd0;
    end else if (addr_load) begin
      addr <= rx_data[1:0];
    end else if (addr_inc) begin
      addr <= addr + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg     <= 8'h00;
      dir_reg     <= 8'h00;
      scratch_reg <= 8'h00;
    end else if (wr_en) begin
      case (addr)
        A_OUT:     out_reg     <= rx_data;
        A_DIR:     dir_reg     <= rx_data;
        A_SCRATCH: scratch_reg <= rx_data;
        default:   ;
      endcase
    end
  end

  // Setting the error flag outranks a simultaneous write-one-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (err_set) begin
      err_sticky <= 1'b1;
    end else if (wr_en && (addr == A_STATUS) && rx_data[0]) begin
      err_sticky <= 1'b0;
    end
  end

  // Frames that ended without a single accepted byte are not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_seen <= 1'b0;
      frame_cnt  <= 4'd0;
    end else if (frame_end) begin
      frame_seen <= 1'b0;
      if (frame_seen) frame_cnt <= frame_cnt + 4'd1;
    end else if (byte_ok && frame_active) begin
      frame_seen <= 1'b1;
    end
  end

  assign status = {frame_cnt, 2'b00, frame_active, err_sticky};

  always_comb begin
    rd_mux = 8'h00;
    case (addr)
      A_OUT:     rd_mux = out_reg;
      A_DIR:     rd_mux = dir_reg;
      A_SCRATCH: rd_mux = scratch_reg;
      A_STATUS:  rd_mux = status;
      default:   rd_mux = 8'h00;
    endcase
  end

  // The load lags the byte by one edge so rd_mux sees the updated address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_req <= 1'b0;
      tx_data  <= 8'h00;
      tx_latch <= 1'b0;
    end else begin
      load_req <= load_set;
      if (load_req && !ss) begin
        tx_data  <= rd_mux;
        tx_latch <= 1'b1;
      end else begin
        tx_latch <= 1'b0;
      end
    end
  end

  assign pin_out = out_reg & dir_reg;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: byte-level frames driven through the
// rx_rdy/ss handshake, tx_latch loads collected and scored against exp_q.
module tb_spi_reg_ctrl;

  logic       clk;
  logic       rst;
  logic       ss;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic [7:0] tx_data;
  logic       tx_latch;
  logic [7:0] pin_out;
  logic       busy;

  int n_cmp;
  int n_bad;
  int dbl_latch;
  logic prev_latch;

  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];

  spi_reg_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .ss       (ss),
    .rx_data  (rx_data),
    .rx_rdy   (rx_rdy),
    .tx_data  (tx_data),
    .tx_latch (tx_latch),
    .pin_out  (pin_out),
    .busy     (busy)
  );

  // ------------------------------------------------ clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Collect every tx_latch load and note any back-to-back pulse.
  always @(negedge clk) begin
    if (tx_latch) cap_q.push_back(tx_data);
    if (tx_latch && prev_latch) dbl_latch = dbl_latch + 1;
    prev_latch = tx_latch;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------ driver tasks
  task automatic start_frame();
    @(negedge clk);
    ss = 1'b0;
    @(negedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk);
    ss = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    @(negedge clk);
    rx_rdy  = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_frame(input logic [7:0] cmd, input logic [7:0] d);
    start_frame();
    send_byte(cmd);
    send_byte(d);
    end_frame();
  endtask

  task automatic read_frame(input string tag, input logic [7:0] cmd, input int n_dummy);
    logic [7:0] e;
    logic [7:0] g;
    cap_q.delete();
    start_frame();
    send_byte(cmd);
    for (int i = 0; i < n_dummy; i++) send_byte(8'hC3);
    end_frame();
    check({tag, "_cnt"}, cap_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (cap_q.size() > 0) ? cap_q.pop_front() : 8'hxx;
      check(tag, g, e);
    end
  endtask

  // ------------------------------------------------ stimulus
  initial begin
    n_cmp = 0; n_bad = 0; dbl_latch = 0; prev_latch = 1'b0;
    rst = 1'b1; ss = 1'b1; rx_data = 8'h00; rx_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_pin", pin_out, 8'h00);
    check("rst_tx", tx_data, 8'h00);
    check("rst_latch", tx_latch, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    // DIR write alone leaves pins low
    write_frame(8'h01, 8'hFF);
    check("dir_pin", pin_out, 8'h00);
    exp_q = '{8'hFF, 8'h00, 8'h12, 8'h00};
    read_frame("rd_dir", 8'h81, 3);

    // burst write with auto-increment, then open DIR fully
    start_frame();
    send_byte(8'h00); send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h3C);
    check("burst_busy", busy, 1);
    end_frame();
    check("burst_pin", pin_out, 8'h00);
    write_frame(8'h01, 8'hFF);
    check("open_pin", pin_out, 8'hA5);

    // read burst wraps SCRATCH -> STATUS -> OUT
    write_frame(8'h02, 8'h77);
    exp_q = '{8'h77, 8'h52, 8'hA5};
    read_frame("rd_wrap", 8'h82, 2);

    // malformed command: all following bytes ignored
    start_frame();
    send_byte(8'h44); send_byte(8'h00); send_byte(8'hEE);
    check("err_busy", busy, 1);
    end_frame();
    check("err_pin", pin_out, 8'hA5);
    exp_q = '{8'h73};
    read_frame("rd_err", 8'h83, 0);
    write_frame(8'h03, 8'hFE);
    exp_q = '{8'h93};
    read_frame("rd_w1c0", 8'h83, 0);
    write_frame(8'h03, 8'h01);
    exp_q = '{8'hB2, 8'hA5};
    read_frame("rd_w1c1", 8'h83, 1);

    // rx_rdy held high gives one byte; ss beats a coincident strobe
    start_frame();
    send_byte(8'h00);
    @(negedge clk);
    rx_data = 8'h0F;
    rx_rdy  = 1'b1;
    repeat (10) @(negedge clk);
    rx_rdy = 1'b0;
    @(negedge clk);
    check("hold_pin", pin_out, 8'h0F);
    ss      = 1'b1;
    rx_data = 8'h00;
    rx_rdy  = 1'b1;
    @(negedge clk);
    check("ss_prio_busy", busy, 0);
    rx_rdy = 1'b0;
    @(negedge clk);
    check("ss_prio_pin", pin_out, 8'h0F);
    exp_q = '{8'hFF};
    read_frame("rd_hold", 8'h81, 0);

    // reset in the middle of a write burst
    start_frame();
    send_byte(8'h00);
    send_byte(8'h3C);
    check("pre_rst_pin", pin_out, 8'h3C);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pin", pin_out, 8'h00);
    check("mid_rst_tx", tx_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 1);
    end_frame();
    exp_q = '{8'h02, 8'h00, 8'h00, 8'h00};
    read_frame("rd_post_rst", 8'h83, 3);
    write_frame(8'h00, 8'h55);
    write_frame(8'h01, 8'h0F);
    check("post_rst_pin", pin_out, 8'h05);

    check("latch_double", dbl_latch, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
